// File: rtl/dip_pkg.sv
// rtl/dip_pkg.sv - shared types and defaults for the DIP switch debounce front end
//
// Purpose: state encoding and default constants used by dip_debounce and
//          dip_debounce_bit.
// Ports  : none (package).

package dip_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } dip_state_t;

   localparam int DIP_WIDTH            = 4;
   localparam int DIP_DEBOUNCE_DEFAULT = 240000;

endpackage

// File: rtl/dip_debounce_bit.sv
// rtl/dip_debounce_bit.sv - one switch bit: synchroniser, stability counter, level and edge pulses
//
// Purpose: brings one raw switch pin into the clk domain and only accepts a new
//          level after DEBOUNCE_CYCLES consecutive cycles of disagreement with
//          the current level.
// Ports  :
//   clk       in   clock
//   rst_n     in   synchronous active-low reset
//   run_i     in   1 = debounce active, 0 = settle phase (level tracks sync directly)
//   raw_i     in   raw asynchronous switch pin
//   level_o   out  debounced level (registered)
//   rise_o    out  one-cycle pulse on an accepted 0->1 transition (registered)
//   fall_o    out  one-cycle pulse on an accepted 1->0 transition (registered)
//   accept_o  out  next-cycle pulse indication, lets the parent register its OR
//                  in the same cycle as rise_o/fall_o

module dip_debounce_bit
   import dip_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic accept_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             level_q, level_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!run_i) begin
         // Settle phase: adopt whatever the pins show, no edges reported.
         level_d = sync2_q;
         cnt_d   = '0;
      end else if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // DEBOUNCE_CYCLES-th consecutive mismatch: accept the new level.
         level_d = sync2_q;
         cnt_d   = '0;
         rise_d  = sync2_q;
         fall_d  = ~sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o  = level_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign accept_o = rise_d | fall_d;

endmodule

// File: rtl/dip_debounce.sv
// rtl/dip_debounce.sv - DIP switch bank debounce/synchronisation front end
//
// Purpose: per-bit debounce of the raw DIP pins plus a global settle FSM that
//          holds off edge reporting until the switches have been observed for
//          one full debounce window after reset.
// Ports  :
//   clk           in   clock
//   rst_n         in   synchronous active-low reset
//   dips_raw      in   [WIDTH] raw switch pins, asynchronous to clk
//   dips_out      out  [WIDTH] debounced levels
//   dips_rise     out  [WIDTH] one-cycle pulses on accepted 0->1
//   dips_fall     out  [WIDTH] one-cycle pulses on accepted 1->0
//   dips_changed  out  OR of all rise/fall pulses, same cycle
//   ready         out  high once the initial settle window has completed

module dip_debounce
   import dip_pkg::*;
#(
   parameter int WIDTH           = DIP_WIDTH,
   parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] dips_raw,
   output logic [WIDTH-1:0] dips_out,
   output logic [WIDTH-1:0] dips_rise,
   output logic [WIDTH-1:0] dips_fall,
   output logic             dips_changed,
   output logic             ready
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   dip_state_t       state_q;
   logic [CNT_W-1:0] settle_q;
   logic             ready_q;
   logic             changed_q;
   logic [WIDTH-1:0] accept_w;
   logic             run_w;

   assign run_w = (state_q == RUN);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      dip_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .clk      (clk),
         .rst_n    (rst_n),
         .run_i    (run_w),
         .raw_i    (dips_raw[g]),
         .level_o  (dips_out[g]),
         .rise_o   (dips_rise[g]),
         .fall_o   (dips_fall[g]),
         .accept_o (accept_w[g])
      );
   end

   // Settle FSM. The bits still see run_w=0 on the edge that enters RUN, so
   // no pulse can coincide with ready rising.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= INIT;
         settle_q  <= '0;
         ready_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         changed_q <= |accept_w;
         case (state_q)
            INIT: begin
               if (settle_q == SETTLE_LAST) begin
                  state_q  <= RUN;
                  ready_q  <= 1'b1;
                  settle_q <= '0;
               end else begin
                  settle_q <= settle_q + 1'b1;
               end
            end
            RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= INIT;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready        = ready_q;
   assign dips_changed = changed_q;

endmodule

// File: tb/tb_dip_debounce.sv
// tb/tb_dip_debounce.sv - scoreboard testbench for dip_debounce (WIDTH=4, DEBOUNCE_CYCLES=8)

module tb_dip_debounce;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] dips_raw = 4'b1010;
   logic [3:0] dips_out, dips_rise, dips_fall;
   logic       dips_changed, ready;

   dip_debounce #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dips_raw     (dips_raw),
      .dips_out     (dips_out),
      .dips_rise    (dips_rise),
      .dips_fall    (dips_fall),
      .dips_changed (dips_changed),
      .ready        (ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int         cyc;
      bit         is_ready;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] out;
   } ev_t;

   ev_t exp_q[$];

   task automatic push_pulse(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] o);
      ev_t e;
      e.cyc = c; e.is_ready = 1'b0; e.rise = r; e.fall = f; e.out = o;
      exp_q.push_back(e);
   endtask

   task automatic push_ready(input int c);
      ev_t e;
      e.cyc = c; e.is_ready = 1'b1; e.rise = 4'b0; e.fall = 4'b0; e.out = 4'b0;
      exp_q.push_back(e);
   endtask

   // Park at the negative edge that follows posedge number c.
   task automatic to_neg(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
   endtask

   // Monitor: every ready rise or dips_changed pulse must match the head of the queue.
   logic ready_prev = 1'b0;
   always @(negedge clk) begin
      ev_t e;
      chk("changed_is_or", {31'b0, dips_changed}, {31'b0, |(dips_rise | dips_fall)});
      if (ready && !ready_prev) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ready_rise", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ready_is_expected_kind", {31'b0, e.is_ready}, 32'd1);
            chk("ready_cycle", cyc, e.cyc);
            chk("ready_no_rise", {28'b0, dips_rise}, 32'd0);
            chk("ready_no_fall", {28'b0, dips_fall}, 32'd0);
         end
      end else if (dips_changed) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {24'b0, dips_rise, dips_fall}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_is_expected_kind", {31'b0, e.is_ready}, 32'd0);
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_rise", {28'b0, dips_rise}, {28'b0, e.rise});
            chk("pulse_fall", {28'b0, dips_fall}, {28'b0, e.fall});
            chk("pulse_out",  {28'b0, dips_out},  {28'b0, e.out});
         end
      end
      ready_prev = ready;
   end

   initial begin
      // Reset held with pins at 1010.
      to_neg(3);
      chk("rst_out",     {28'b0, dips_out},  32'd0);
      chk("rst_rise",    {28'b0, dips_rise}, 32'd0);
      chk("rst_fall",    {28'b0, dips_fall}, 32'd0);
      chk("rst_changed", {31'b0, dips_changed}, 32'd0);
      chk("rst_ready",   {31'b0, ready}, 32'd0);

      // Release at cycle 3: first active edge is 4, ready after edge 11.
      rst_n = 1'b1;
      push_ready(11);
      to_neg(5);
      chk("init_out_pipeline", {28'b0, dips_out}, 32'h0);
      to_neg(6);
      chk("init_out_loaded", {28'b0, dips_out}, 32'ha);
      to_neg(10);
      chk("init_not_ready", {31'b0, ready}, 32'd0);

      // Clean flip of bit0: accepted 10 cycles later.
      to_neg(14);
      dips_raw = 4'b1011;
      push_pulse(24, 4'b0001, 4'b0000, 4'b1011);

      // Bounce on bit1 (currently 1): 5 away, 2 back, 5 away, then back for good.
      to_neg(27); dips_raw = 4'b1001;
      to_neg(32); dips_raw = 4'b1011;
      to_neg(34); dips_raw = 4'b1001;
      to_neg(39); dips_raw = 4'b1011;
      to_neg(55);
      chk("bounce_out_unchanged", {28'b0, dips_out}, 32'hb);

      // Simultaneous: bit3 1->0, bit2 0->1.
      dips_raw = 4'b0111;
      push_pulse(65, 4'b0100, 4'b1000, 4'b0111);

      // Repeat spacing on bit0: pins flip 8 cycles apart, pulses land 8 apart.
      to_neg(70); dips_raw = 4'b0110;
      push_pulse(80, 4'b0000, 4'b0001, 4'b0110);
      to_neg(78); dips_raw = 4'b0111;
      push_pulse(88, 4'b0001, 4'b0000, 4'b0111);

      // Reset mid-debounce: bit0 counter reaches 5 after edge 102.
      to_neg(95); dips_raw = 4'b0110;
      to_neg(102); rst_n = 1'b0;
      to_neg(103);
      chk("midrst_out",     {28'b0, dips_out},  32'd0);
      chk("midrst_rise",    {28'b0, dips_rise}, 32'd0);
      chk("midrst_fall",    {28'b0, dips_fall}, 32'd0);
      chk("midrst_changed", {31'b0, dips_changed}, 32'd0);
      chk("midrst_ready",   {31'b0, ready}, 32'd0);
      rst_n = 1'b1;
      push_ready(111);
      to_neg(106);
      chk("midrst_out_reloaded", {28'b0, dips_out}, 32'h6);

      to_neg(125);
      chk("final_out", {28'b0, dips_out}, 32'h6);
      chk("all_events_seen", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dip_debounce.md
# dip_debounce

Debounce and synchronisation front end for the board's DIP switch bank. Sits directly upstream of the DIP-to-LED stage: raw asynchronous switch pins enter here, and the block delivers clean, clock-domain-aligned switch levels plus one-cycle change strobes to the `dips_in` input of the LED driver stage. It removes metastability and contact bounce so downstream logic sees at most one transition per physical switch flip.

## Interface
- `WIDTH`, default 4: number of switch bits.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required before accepting a new level (20 ms at 12 MHz). Legal range is 2 and up.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width. It is derived and must not be overridden.

- `clk`  in  1: the single clock domain.
- `rst_n`  in  1: synchronous, active-low reset.
- `dips_raw`  in  WIDTH: raw switch pins; asynchronous to `clk`.
- `dips_out`  out  WIDTH: debounced switch levels.
- `dips_rise`  out  WIDTH: one-cycle pulse per bit on an accepted 0→1 transition.
- `dips_fall`  out  WIDTH: one-cycle pulse per bit on an accepted 1→0 transition.
- `dips_changed`  out  1: OR of all `dips_rise` and `dips_fall` bits, registered in the same cycle.
- `ready`  out  1: high once the initial settle window has completed.

## Operation
**Synchroniser**
- Each bit passes through a 2-flop synchroniser, producing `sync`.
- Both synchroniser flops reset to 0.

**Control FSM** (2 states, global)
- `INIT` (the reset state):
  - A settle counter counts clk cycles.
  - `dips_out` loads `sync` every cycle.
  - All pulse outputs are held at 0 and `ready` is 0.
  - When the settle counter reaches `DEBOUNCE_CYCLES-1`, the FSM moves to `RUN` on the next edge.
- `RUN`:
  - `ready` is 1.
  - Per-bit debounce is active.
  - The FSM stays in `RUN` until reset.

**Per-bit debounce** (RUN only)
- If `sync[i] == dips_out[i]`: `cnt[i]` clears to 0.
- Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`:
  - `dips_out[i]` takes the value of `sync[i]`.
  - `cnt[i]` clears to 0.
  - The matching `dips_rise[i]` or `dips_fall[i]` pulses for exactly one cycle.
- Otherwise `cnt[i]` increments.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles resets the count and produces no output change.
- Bits are fully independent. Several bits may accept in the same cycle; `dips_changed` is then a single pulse, and each bit's own rise/fall pulse is set.

**Reset**
- Reset values: `dips_out=0`, `dips_rise=0`, `dips_fall=0`, `dips_changed=0`, `ready=0`, all counters 0, FSM in `INIT`.
- Reset asserted mid-debounce or mid-pulse clears everything at the next edge; no pulse survives reset.

**Counter width**
- `cnt` saturates logically at `DEBOUNCE_CYCLES-1` and never wraps.

## Timing
- Synchroniser latency: 2 cycles from a stable `dips_raw` change to `sync`.
- Debounce latency in RUN:
  - After `sync` first differs from `dips_out`, `dips_out` updates on the DEBOUNCE_CYCLES-th edge of continuous mismatch.
  - Total latency from `dips_raw` to `dips_out` is DEBOUNCE_CYCLES+2 cycles.
- The pulse outputs are registered and are high in the same cycle that `dips_out` first shows the new value.
- `ready` rises exactly DEBOUNCE_CYCLES cycles after the first clock edge with `rst_n=1`.
- No pulse is ever produced in the cycle `ready` rises.
- Minimum spacing between two accepted transitions on one bit is DEBOUNCE_CYCLES cycles.

## Structure
- A shared package `dip_pkg` holds:
  - the state enum `dip_state_t` (`INIT`, `RUN`);
  - the default constants `DIP_WIDTH=4` and `DIP_DEBOUNCE_DEFAULT=240000`.
- The sub-module `dip_debounce_bit` contains one bit's synchroniser, counter, level and rise/fall pulses. It is generate-instanced WIDTH times.
- The top level `dip_debounce` holds the FSM, the settle counter, the `dips_changed` OR reduction and the `ready` output.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=8` and `WIDTH=4`.
- **Reset/INIT:** hold `dips_raw=4'b1010` through reset release.
  - `dips_out=4'b1010` from the 3rd cycle onward.
  - `ready` rises on cycle 8.
  - No pulses are produced.
- **Clean flip:** in RUN, change bit0 from 0 to 1 and hold.
  - `dips_out[0]` is 1 exactly 10 cycles later.
  - `dips_rise=4'b0001` and `dips_changed=1` for 1 cycle.
  - `dips_fall` stays 0.
- **Bounce rejection:** toggle bit1 with a 5-cycle high, 2-cycle low, 5-cycle high pattern, then release low.
  - `dips_out[1]` never changes.
  - No pulses are produced.
- **Simultaneous:** change bits 3 and 2 together, with bit3 1→0 and bit2 0→1.
  - The same cycle shows `dips_fall=4'b1000`, `dips_rise=4'b0100` and a single `dips_changed` pulse.
- **Reset mid-debounce:** assert `rst_n=0` when `cnt[0]=5`.
  - Next cycle: all outputs are 0 and the FSM is in `INIT`.
  - After release, `ready` returns after 8 cycles with no pulse.
- **Repeat spacing:** flip bit0 twice, 8 cycles apart after the first acceptance.
  - Two pulses are produced, exactly 8 cycles apart.
